muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have no parameters; data width is fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operation request from decode; operands read from the register file.
REQ-005 in_ready  output  1  unit can accept a request; high only in IDLE.
REQ-006 funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 rs1_data, rs2_data  input  32 each  operands A and B.
REQ-008 rd_addr  input  5  destination register; carried through unchanged.
REQ-009 out_valid  output  1  result available for register-file writeback.
REQ-010 out_ready  input  1  writeback consumer accepts the result.
REQ-011 out_data  output  32  result; out_rd_addr  output  5  destination tag.
REQ-012 busy  output  1  high in every state except IDLE; used by hazard logic to stall.

Function
REQ-013 The unit SHALL accept a request on a clock edge where in_valid && in_ready, and SHALL latch funct3, operands and rd_addr at that edge.
REQ-014 FSM states SHALL be IDLE, CALC, FIX and DONE.
REQ-015 IDLE->CALC on accept, except for the special divide cases in REQ-020/021, which go IDLE->DONE.
REQ-016 CALC SHALL run exactly 32 iterations on a 6-bit counter: multiply by shift-add on operand magnitudes; divide by restoring division (one quotient bit per cycle).
REQ-017 After iteration 32, CALC->FIX; FIX SHALL apply sign correction in one cycle, then go to DONE.
REQ-018 Normal latency SHALL be fixed: out_valid rises on the 34th rising edge after the accepting edge.
REQ-019 Signedness rules:
- MULH treats both operands as signed.
- MULHSU treats A as signed and B as unsigned.
- MUL returns the low 32 bits of the product.
- MULH* return the high 32 bits of the 64-bit product.
- The quotient is negative iff the operand signs differ (signed ops).
- The remainder takes the sign of the dividend.
REQ-020 Divide by zero (B==0) SHALL produce a result 1 cycle after accept:
- DIV/DIVU: 0xFFFFFFFF.
- REM/REMU: A.
REQ-021 Signed overflow (DIV/REM, A=0x80000000, B=0xFFFFFFFF) SHALL produce a result 1 cycle after accept: DIV gives 0x80000000, REM gives 0.
REQ-022 In DONE, out_valid SHALL stay high, and out_data and out_rd_addr SHALL stay stable, until out_ready is sampled high.
REQ-023 On an edge with out_valid && out_ready, the unit SHALL return to IDLE; in_ready rises the following cycle. There is no back-to-back accept in the same edge.
REQ-024 in_valid SHALL be ignored outside IDLE; operand changes during CALC/FIX/DONE SHALL not affect the result.
REQ-025 rd_addr == 0 SHALL be processed normally; discarding the write is the register file's responsibility.
REQ-026 out_ready asserted while out_valid is low SHALL have no effect.

Reset
REQ-027 While reset_n is low, the unit SHALL be in IDLE with:
- in_ready = 1, busy = 0, out_valid = 0;
- out_data = 0, out_rd_addr = 0;
- counter and datapath registers = 0.
REQ-028 Reset asserted mid-operation (any state) SHALL abort immediately; no result is ever presented for the aborted operation.
REQ-029 The first accept is allowed on the first rising edge after reset_n deasserts.

Structure
REQ-030 The shared package mini_rv_pkg SHALL hold:
- the muldiv_op_t enum (the eight funct3 encodings);
- the muldiv_state_t enum;
- constant XLEN = 32.
REQ-031 Implementation SHALL be a single module with one shared 64-bit shift register for multiply and divide; no sub-module.

Verification
REQ-032 MUL, A=7, B=0xFFFFFFFD -> out_data 0xFFFFFFEB exactly 34 cycles after accept; MULHU with A=B=0xFFFFFFFF -> 0xFFFFFFFE.
REQ-033 MULHSU, A=0xFFFFFFFF (-1), B=0xFFFFFFFF -> 0xFFFFFFFF; MULH with the same operands -> 0x00000000.
REQ-034 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-035 DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000. Each result valid 1 cycle after accept.
REQ-036 Hold out_ready low 5 cycles in DONE -> out_valid and out_data held; in_ready stays 0; a new in_valid is ignored.
REQ-037 Pull reset_n low at iteration 10 of a DIV -> busy = 0, out_valid = 0 immediately; the next request completes correctly.

Source files
------------

// File: rtl/mini_rv_pkg.sv
// Shared definitions for the mini RV32 core: data width, RV32M operation
// encodings (funct3) and the multiply/divide unit state encoding.
package mini_rv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// One request is accepted in IDLE (in_valid && in_ready). Multiplies use
// shift-add and divides use restoring division on operand magnitudes, both
// in one shared 64-bit shift register, one bit per cycle for 32 cycles; a
// final cycle applies sign correction. Divide-by-zero and signed overflow
// bypass the iteration and present their fixed result right after accept.
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   in_valid / in_ready       request handshake (in_ready only in IDLE)
//   funct3                    RV32M operation select
//   rs1_data, rs2_data        operands A and B
//   rd_addr                   destination tag, carried to out_rd_addr
//   out_valid / out_ready     result handshake
//   out_data, out_rd_addr     result and its destination tag
//   busy                      high whenever not IDLE
module muldiv_unit
  import mini_rv_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [4:0]      out_rd_addr,
  output logic            busy
);

  muldiv_state_t state, state_next;

  muldiv_op_t        op_q;
  logic [4:0]        rd_q;
  logic [5:0]        cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;      // multiplicand or divisor magnitude
  logic              neg_main;  // negate product / quotient
  logic              neg_rem;   // negate remainder (dividend sign)

  // Request decode
  muldiv_op_t      op_in;
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  always_comb begin
    op_in    = muldiv_op_t'(funct3);
    a_signed = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
               (op_in == OP_DIV)  || (op_in == OP_REM);
    b_signed = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
    a_neg    = a_signed && rs1_data[XLEN-1];
    b_neg    = b_signed && rs2_data[XLEN-1];
    a_mag    = a_neg ? ('0 - rs1_data) : rs1_data;
    b_mag    = b_neg ? ('0 - rs2_data) : rs2_data;
    div_zero = funct3[2] && (rs2_data == '0);
    div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
               (rs1_data == 32'h8000_0000) && (rs2_data == '1);
    special  = div_zero || div_ovf;
    // funct3[1] distinguishes REM* from DIV* among divide ops
    if (div_zero) special_res = funct3[1] ? rs1_data : '1;
    else          special_res = funct3[1] ? '0 : 32'h8000_0000;
  end

  // One iteration step for each kind of operation
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     rem_sh;
  logic              rem_ge;
  logic [2*XLEN-1:0] div_next;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opnd : '0)};
    mul_next = {mul_sum, acc[XLEN-1:1]};
    // Partial remainder shifted left with the next dividend bit; it can
    // reach 33 bits, but after subtraction the result always fits in 32.
    rem_sh   = acc[2*XLEN-1:XLEN-1];
    rem_ge   = rem_sh >= {1'b0, opnd};
    div_next = {rem_sh[XLEN-1:0] - (rem_ge ? opnd : '0), acc[XLEN-2:0], rem_ge};
  end

  // Sign correction
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem, fix_res;

  always_comb begin
    prod = neg_main ? ('0 - acc) : acc;
    quot = neg_main ? ('0 - acc[XLEN-1:0]) : acc[XLEN-1:0];
    rem  = neg_rem  ? ('0 - acc[2*XLEN-1:XLEN]) : acc[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                       fix_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_res = quot;
      OP_REM, OP_REMU:              fix_res = rem;
      default:                      fix_res = '0;
    endcase
  end

  // FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (in_valid) state_next = special ? S_DONE : S_CALC;
      S_CALC: if (cnt == 6'd32) state_next = S_FIX;
      S_FIX:  state_next = S_DONE;
      S_DONE: if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_DONE);

  // Datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q        <= OP_MUL;
      rd_q        <= '0;
      cnt         <= '0;
      acc         <= '0;
      opnd        <= '0;
      neg_main    <= 1'b0;
      neg_rem     <= 1'b0;
      out_data    <= '0;
      out_rd_addr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q     <= op_in;
            rd_q     <= rd_addr;
            cnt      <= '0;
            acc      <= {{XLEN{1'b0}}, a_mag};
            opnd     <= b_mag;
            neg_main <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            if (special) begin
              out_data    <= special_res;
              out_rd_addr <= rd_addr;
            end
          end
        end
        S_CALC: begin
          // The cycle with cnt == 32 only hands over to FIX.
          if (cnt != 6'd32) begin
            acc <= op_q[2] ? div_next : mul_next;
            cnt <= cnt + 6'd1;
          end
        end
        S_FIX: begin
          out_data    <= fix_res;
          out_rd_addr <= rd_q;
        end
        default: ;
      endcase
    end
  end

endmodule
